divider_result_checker: RTL and testbench
=========================================

// Module: divider_result_checker
// PURPOSE
//   Inverse companion to the reciprocal divider: takes a divider result (quotient q,
//   remainder r) plus the divisor v and reconstructs the dividend as p = q*v + r.
//   Uses an iterative shift-add multiplier with a valid/ready handshake on both sides.
//   Compares p against the expected dividend u_exp and flags the result.
//   Sits behind the divider in self-check datapaths and test harnesses.
// PARAMETERS
//   WIDTH  16  operand width of q, v, r, u_exp; product path is 2*WIDTH bits
// PORTS
//   clk        input   1        single system clock, rising-edge
//   rst        input   1        synchronous, active-high reset
//   in_valid   input   1        q/v/r/u_exp valid
//   in_ready   output  1        block can accept operands
//   q          input   WIDTH    quotient from divider
//   v          input   WIDTH    divisor
//   r          input   WIDTH    remainder from divider
//   u_exp      input   WIDTH    expected dividend
//   out_valid  output  1        p/match valid
//   out_ready  input   1        downstream accepts result
//   p          output  2*WIDTH  reconstructed q*v + r
//   match      output  1        1 when p == zero-extended u_exp
//   busy       output  1        1 in RUN or DONE
// BEHAVIOUR
//   Reset (rst=1 at a rising edge): state=IDLE. Outputs: in_ready=1, out_valid=0,
//     p=0, match=0, busy=0. Applies from any state; an in-flight operation is discarded.
//   FSM states: IDLE, RUN, DONE.
//   IDLE: in_ready=1. On an edge with in_valid=1:
//     - latch mq=q and mv=zero-ext(v) (2*WIDTH bits), and u_exp;
//     - set acc=zero-ext(r) and cnt=0;
//     - go to RUN.
//   RUN: in_ready=0. Each edge:
//     - if mq[0]=1, acc += mv;
//     - mq >>= 1, mv <<= 1, cnt++;
//     - when cnt==WIDTH-1, this is the final step: go to DONE.
//     - Fixed latency: out_valid rises exactly WIDTH edges after the accepting edge.
//     - No early termination.
//   DONE: out_valid=1. p=acc and match=(acc=={WIDTH'b0,u_exp}), both stable while held.
//     - On an edge with out_ready=1: go to IDLE and drop out_valid.
//     - out_ready=0 holds the result indefinitely.
//   in_ready is asserted only in IDLE, so DONE->IDLE->accept takes at least one extra edge.
//     Max throughput is one result per WIDTH+2 cycles.
//   Input changes while not in IDLE are ignored; the latched copies are used.
//   Arithmetic: unsigned. Max p = (2^W-1)^2 + (2^W-1) < 2^(2W), so no overflow.
//   q=0 or v=0 gives p=r. v=0 is not special-cased.
//   p and match keep their last values after leaving DONE until the next DONE.
//     Only out_valid qualifies them.
//   busy = (state != IDLE).
// TESTING
//   1. q=4, v=25, r=1, u_exp=101 -> p=101, match=1. out_valid rises 16 edges after acceptance.
//   2. q=257, v=255, r=0, u_exp=65535 -> p=65535, match=1.
//      q=949, v=13, r=8, u_exp=12345 -> p=12345, match=1.
//   3. q=65535, v=65535, r=65535, u_exp=0 -> p=4294901760, match=0 (max-width corner).
//   4. q=0, v=5, r=0, u_exp=0 -> p=0, match=1.
//      q=1, v=1, r=0, u_exp=2 -> p=1, match=0.
//   5. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, p, match stable
//      and in_ready=0. Then pulse out_ready -> IDLE and in_ready=1 the next cycle.
//   6. Assert rst 5 cycles into RUN -> next edge: IDLE, out_valid=0, p=0, in_ready=1.
//      A following op q=200, v=25, r=0 -> p=5000.

Source files
------------

// File: rtl/divider_result_checker.sv
// Reconstructs a dividend from a divider result as p = q*v + r using a one-bit-per-cycle
// shift-add multiplier, then flags whether p equals the expected dividend.
module divider_result_checker #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     q,
    input  logic [WIDTH-1:0]     v,
    input  logic [WIDTH-1:0]     r,
    input  logic [WIDTH-1:0]     u_exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 match,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [WIDTH-1:0] r_mq;
    logic [PW-1:0]    r_mv;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_uexp;
    logic [PW-1:0]    r_p;
    logic             r_match;

    logic [PW-1:0]    w_acc_step;
    logic             w_last;

    assign w_acc_step = r_mq[0] ? (r_acc + r_mv) : r_acc;
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath. p/match are captured on the final RUN step so they hold across
    // DONE and keep their value after returning to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mq    <= '0;
            r_mv    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_uexp  <= '0;
            r_p     <= '0;
            r_match <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mq   <= q;
                        r_mv   <= {{WIDTH{1'b0}}, v};
                        r_acc  <= {{WIDTH{1'b0}}, r};
                        r_cnt  <= '0;
                        r_uexp <= u_exp;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_step;
                    r_mq  <= r_mq >> 1;
                    r_mv  <= r_mv << 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_p     <= w_acc_step;
                        r_match <= (w_acc_step == {{WIDTH{1'b0}}, r_uexp});
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign p     = r_p;
    assign match = r_match;

endmodule

// File: tb/tb_divider_result_checker.sv
// Directed bench for divider_result_checker: latency, arithmetic corners,
// backpressure and mid-operation reset.
module tb_divider_result_checker;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] q;
    logic [15:0] v;
    logic [15:0] r;
    logic [15:0] u_exp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p;
    logic        match;
    logic        busy;

    int pass_cnt;
    int total_cnt;

    divider_result_checker #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .v         (v),
        .r         (r),
        .u_exp     (u_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .match     (match),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start an operation and wait for out_valid; leaves the block in DONE.
    task automatic start_and_wait(input logic [15:0] a_q, input logic [15:0] a_v,
                                  input logic [15:0] a_r, input logic [15:0] a_u,
                                  input logic [31:0] e_p, input logic e_m, input string name);
        int lat;
        @(negedge clk);
        q = a_q; v = a_v; r = a_r; u_exp = a_u;
        in_valid = 1'b1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL %s accept: in_ready=%b required 1", name, in_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        q = 16'hdead; v = 16'hbeef; r = 16'h1234; u_exp = 16'h5678;
        total_cnt++;
        if (busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL %s run_flags: busy=%b in_ready=%b required 1/0", name, busy, in_ready);
        else pass_cnt++;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        total_cnt++;
        if (lat !== 16) $display("FAIL %s latency: got %0d edges required 16", name, lat);
        else pass_cnt++;
        total_cnt++;
        if (p !== e_p || match !== e_m)
            $display("FAIL %s result: p=%0d match=%b required p=%0d match=%b", name, p, match, e_p, e_m);
        else pass_cnt++;
        $display("op %s: q=%0d v=%0d r=%0d u_exp=%0d -> p=%0d match=%b lat=%0d",
                 name, a_q, a_v, a_r, a_u, p, match, lat);
    endtask

    task automatic release_result(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b required 0/1/0",
                     name, out_valid, in_ready, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== 32'd0 || match !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_state: in_ready=%b out_valid=%b p=%0d match=%b busy=%b required 1/0/0/0/0",
                     in_ready, out_valid, p, match, busy);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        start_and_wait(16'd4, 16'd25, 16'd1, 16'd101, 32'd101, 1'b1, "basic");
        release_result("basic");
    endtask

    task automatic test_patterns();
        start_and_wait(16'd257, 16'd255, 16'd0, 16'd65535, 32'd65535, 1'b1, "pat_257x255");
        release_result("pat_257x255");
        start_and_wait(16'd949, 16'd13, 16'd8, 16'd12345, 32'd12345, 1'b1, "pat_949x13");
        release_result("pat_949x13");
    endtask

    task automatic test_max_width();
        start_and_wait(16'hffff, 16'hffff, 16'hffff, 16'd0, 32'd4294901760, 1'b0, "max");
        release_result("max");
    endtask

    task automatic test_zero_and_mismatch();
        start_and_wait(16'd0, 16'd5, 16'd0, 16'd0, 32'd0, 1'b1, "q_zero");
        release_result("q_zero");
        start_and_wait(16'd1, 16'd1, 16'd0, 16'd2, 32'd1, 1'b0, "mismatch");
        release_result("mismatch");
        start_and_wait(16'd77, 16'd0, 16'd9, 16'd9, 32'd9, 1'b1, "v_zero");
        release_result("v_zero");
    endtask

    task automatic test_backpressure();
        int bad;
        start_and_wait(16'd300, 16'd7, 16'd5, 16'd2105, 32'd2105, 1'b1, "bp");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || p !== 32'd2105 || match !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad !== 0)
            $display("FAIL backpressure_hold: %0d unstable cycles required 0 (out_valid=%b p=%0d match=%b in_ready=%b)",
                     bad, out_valid, p, match, in_ready);
        else pass_cnt++;
        release_result("bp");
        @(posedge clk); #1;
        total_cnt++;
        if (p !== 32'd2105 || match !== 1'b1)
            $display("FAIL hold_after_done: p=%0d match=%b required 2105/1", p, match);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_run();
        @(negedge clk);
        q = 16'd1000; v = 16'd3; r = 16'd0; u_exp = 16'd3000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b0 || p !== 32'd0 || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_in_run: out_valid=%b p=%0d in_ready=%b busy=%b required 0/0/1/0",
                     out_valid, p, in_ready, busy);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        start_and_wait(16'd200, 16'd25, 16'd0, 16'd5000, 32'd5000, 1'b1, "after_rst");
        release_result("after_rst");
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        q = '0; v = '0; r = '0; u_exp = '0;
        test_reset();
        test_basic();
        test_patterns();
        test_max_width();
        test_zero_and_mismatch();
        test_backpressure();
        test_reset_in_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
